// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared FP32 field constants, FSM state encoding and a
//               leading-zero-count helper for the shared FP adder scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // IEEE-754 single-precision field layout
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    // Sequencing FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_PACK  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Number of zeros above the most significant set bit of a 24-bit value.
    // An all-zero input returns 24.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end
        end
        return n;
    endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-wide round-robin arbiter. Grants the first asserted request
//               at or after the rotating pointer (wrapping). When enabled and a
//               grant is issued, the pointer advances to one past the winner.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               en               - grants allowed this cycle
//               req[N-1:0]       - request vector
//               grant[N-1:0]     - one-hot grant (zero when disabled/no req)
//               grant_idx[W-1:0] - index of the winner
//               grant_valid      - a grant is being issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] r_ptr;
    logic         w_any;
    logic [W-1:0] w_idx;

    // (base + k) mod N, valid for any N, not only powers of two
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int k);
        return W'((int'(base) + k) % N);
    endfunction

    // Scan from the farthest candidate back to the pointer so the closest
    // asserted request overwrites and wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_add(r_ptr, k)]) begin
                w_any = 1'b1;
                w_idx = wrap_add(r_ptr, k);
            end
        end
        grant = '0;
        if (en && w_any) begin
            grant[w_idx] = 1'b1;
        end
    end

    assign grant_idx   = w_idx;
    assign grant_valid = en & w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && w_any) begin
            r_ptr <= wrap_add(w_idx, 1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fp_add_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_scheduler
// Description : Shares one multi-cycle FP32 adder between N_REQ requesters.
//               A round-robin arbiter picks a requester in IDLE; the FSM then
//               runs ALIGN -> ADD -> NORM -> PACK and presents the tagged
//               result in OUT over a valid/ready handshake. Truncating,
//               subnormals flushed to zero, overflow saturates to infinity.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               req_valid/req_ready   - per-requester request handshake
//               req_a/req_b           - packed FP32 operands, slice i=[32i+:32]
//               res_valid/res_ready   - result handshake
//               res_data, res_id      - A+B and owning requester index
//               busy                  - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_scheduler
    import fp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    output logic [31:0]          res_data,
    output logic [IDX_W-1:0]     res_id,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam logic signed [9:0] c_exp_max = 10'(EXP_MAX);

    state_t            r_state;

    // Captured request
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [IDX_W-1:0]  r_id;

    // ALIGN results: larger-magnitude operand first
    logic              r_lg_sign;
    logic              r_sm_sign;
    logic [7:0]        r_lg_exp;
    logic [23:0]       r_lg_man;
    logic [23:0]       r_sm_man;

    // ADD result
    logic [24:0]       r_sum;

    // NORM results
    logic signed [9:0] r_n_exp;
    logic [22:0]       r_n_man;
    logic              r_n_zero;

    // Registered outputs
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic [IDX_W-1:0]  r_res_id;
    logic              r_busy;

    // ------------------------------------------------------------------
    // Arbitration (only in IDLE)
    // ------------------------------------------------------------------
    logic              w_idle;
    logic [N_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_gnt_any;

    assign w_idle = (r_state == ST_IDLE);

    rr_arbiter #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en          (w_idle),
        .req         (req_valid),
        .grant       (w_grant),
        .grant_idx   (w_gnt_idx),
        .grant_valid (w_gnt_any)
    );

    assign req_ready = w_grant;

    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_a = req_a[32*i +: 32];
                w_sel_b = req_b[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: unpack, order by magnitude, shift the smaller mantissa
    // ------------------------------------------------------------------
    logic [7:0]  w_a_exp, w_b_exp;
    logic [23:0] w_a_man, w_b_man;
    logic        w_a_big;
    logic [7:0]  w_lg_exp, w_sm_exp, w_diff;
    logic [23:0] w_lg_man, w_sm_man, w_sm_aligned;
    logic        w_lg_sign, w_sm_sign;

    assign w_a_exp = r_a[EXP_MSB:EXP_LSB];
    assign w_b_exp = r_b[EXP_MSB:EXP_LSB];
    // A zero exponent flushes the operand (and any subnormal payload) to zero
    assign w_a_man = (w_a_exp == 8'd0) ? 24'd0 : {1'b1, r_a[MAN_W-1:0]};
    assign w_b_man = (w_b_exp == 8'd0) ? 24'd0 : {1'b1, r_b[MAN_W-1:0]};

    // {exp, man} orders magnitudes; flushed operands compare as zero
    assign w_a_big = ({w_a_exp, w_a_man} >= {w_b_exp, w_b_man});

    assign w_lg_exp  = w_a_big ? w_a_exp      : w_b_exp;
    assign w_sm_exp  = w_a_big ? w_b_exp      : w_a_exp;
    assign w_lg_man  = w_a_big ? w_a_man      : w_b_man;
    assign w_sm_man  = w_a_big ? w_b_man      : w_a_man;
    assign w_lg_sign = w_a_big ? r_a[SIGN_BIT] : r_b[SIGN_BIT];
    assign w_sm_sign = w_a_big ? r_b[SIGN_BIT] : r_a[SIGN_BIT];

    assign w_diff       = w_lg_exp - w_sm_exp;
    assign w_sm_aligned = (w_diff >= 8'd25) ? 24'd0 : (w_sm_man >> w_diff);

    // ------------------------------------------------------------------
    // ADD: magnitude add/subtract; large >= small so no borrow out
    // ------------------------------------------------------------------
    logic [24:0] w_sum;

    assign w_sum = (r_lg_sign == r_sm_sign) ? ({1'b0, r_lg_man} + {1'b0, r_sm_man})
                                            : ({1'b0, r_lg_man} - {1'b0, r_sm_man});

    // ------------------------------------------------------------------
    // NORM: carry-out shifts right, otherwise leading-one shifts left
    // ------------------------------------------------------------------
    logic [4:0]        w_lzc;
    logic [23:0]       w_norm_man;
    logic signed [9:0] w_norm_exp;

    always_comb begin
        w_lzc = lzc24(r_sum[23:0]);
        if (r_sum[24]) begin
            w_norm_man = r_sum[24:1];
            w_norm_exp = $signed({2'b00, r_lg_exp}) + 10'sd1;
        end else begin
            w_norm_man = r_sum[23:0] << w_lzc;
            w_norm_exp = $signed({2'b00, r_lg_exp}) - $signed({5'b00000, w_lzc});
        end
    end

    // ------------------------------------------------------------------
    // PACK: underflow to +0, overflow to signed infinity, else truncate
    // ------------------------------------------------------------------
    logic [31:0] w_pack;

    always_comb begin
        if (r_n_zero || (r_n_exp <= 10'sd0)) begin
            w_pack = POS_ZERO;
        end else if (r_n_exp >= c_exp_max) begin
            w_pack = {r_lg_sign, 8'hFF, 23'd0};
        end else begin
            w_pack = {r_lg_sign, r_n_exp[7:0], r_n_man};
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_lg_sign   <= 1'b0;
            r_sm_sign   <= 1'b0;
            r_lg_exp    <= '0;
            r_lg_man    <= '0;
            r_sm_man    <= '0;
            r_sum       <= '0;
            r_n_exp     <= '0;
            r_n_man     <= '0;
            r_n_zero    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_gnt_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_lg_sign <= w_lg_sign;
                    r_sm_sign <= w_sm_sign;
                    r_lg_exp  <= w_lg_exp;
                    r_lg_man  <= w_lg_man;
                    r_sm_man  <= w_sm_aligned;
                    r_state   <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum   <= w_sum;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_n_exp  <= w_norm_exp;
                    r_n_man  <= w_norm_man[22:0];
                    // After normalisation the hidden bit is set unless sum was 0
                    r_n_zero <= ~w_norm_man[23];
                    r_state  <= ST_PACK;
                end
                ST_PACK: begin
                    r_res_data  <= w_pack;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

endmodule : fp_add_scheduler
`default_nettype wire
